// File: rtl/shad_share_arb.sv
// ---------------------------------------------------------------------------
// shad_share_arb
//
// Shares one 64-bit SHAD/SHLD funnel-shift unit between three execute lanes
// (A=0, B=1, C=2). A winning request is registered into an issue stage (S1)
// that drives the combinational shifter. The shifter result is captured into
// a response stage (S2) and returned to the originating lane under per-lane
// backpressure. Each lane has at most one op in flight, so results return
// in order per lane.
//
// Ports:
//   clock, reset          core clock; asynchronous active-low reset
//   req_vld / req_rdy     per-lane request handshake (req_rdy at most one-hot)
//   req_rs/rx/rt/op       packed per-lane operands, lane i in slice i
//   flush                 synchronous pipeline flush (drops S1 and S2)
//   sh_rs/rx/rt/op/lane   operands to the shifter, zero while S1 is empty
//   sh_rn                 combinational shifter result
//   rsp_vld / rsp_rdy     per-lane response handshake (rsp_vld one-hot or 0)
//   rsp_data              result for the lane flagged in rsp_vld
//   busy                  either stage holds an op
// ---------------------------------------------------------------------------
module shad_share_arb #(
    parameter int NLANE = 3,
    parameter bit RR_EN = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NLANE-1:0]    req_vld,
    output logic [NLANE-1:0]    req_rdy,
    input  logic [64*NLANE-1:0] req_rs,
    input  logic [64*NLANE-1:0] req_rx,
    input  logic [8*NLANE-1:0]  req_rt,
    input  logic [6*NLANE-1:0]  req_op,
    input  logic                flush,
    output logic [63:0]         sh_rs,
    output logic [63:0]         sh_rx,
    output logic [7:0]          sh_rt,
    output logic [5:0]          sh_op,
    output logic [1:0]          sh_lane,
    input  logic [63:0]         sh_rn,
    output logic [NLANE-1:0]    rsp_vld,
    input  logic [NLANE-1:0]    rsp_rdy,
    output logic [63:0]         rsp_data,
    output logic                busy
);

    // Issue stage
    logic        s1_v_q, s1_v_d;
    logic [1:0]  s1_lane_q, s1_lane_d;
    logic [63:0] s1_rs_q, s1_rs_d;
    logic [63:0] s1_rx_q, s1_rx_d;
    logic [7:0]  s1_rt_q, s1_rt_d;
    logic [5:0]  s1_op_q, s1_op_d;
    // Response stage
    logic        s2_v_q, s2_v_d;
    logic [1:0]  s2_lane_q, s2_lane_d;
    logic [63:0] s2_data_q, s2_data_d;
    // Round-robin pointer
    logic [1:0]  ptr_q, ptr_d;

    logic             s2_adv, s1_adv;
    logic [NLANE-1:0] held, elig, rot;
    logic [1:0]       start, off, gnt_lane;
    logic [2:0]       off_sum;
    logic             gnt_any;
    logic [63:0]      g_rs, g_rx;
    logic [7:0]       g_rt;
    logic [5:0]       g_op;

    // ---------------------------------------------------------------
    // Advance conditions and grant selection
    // ---------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment, so no latch can be inferred from a missed branch.
        rsp_vld = '0;
        held    = '0;
        for (int i = 0; i < NLANE; i++) begin
            rsp_vld[i] = s2_v_q && (s2_lane_q == 2'(i));
            // A lane with an op still in either stage is not eligible,
            // even if its S2 result is being accepted this very cycle.
            held[i]    = rsp_vld[i] || (s1_v_q && (s1_lane_q == 2'(i)));
        end

        s2_adv = !s2_v_q || |(rsp_vld & rsp_rdy);
        s1_adv = !s1_v_q || s2_adv;

        // Grants are also held off while reset is asserted so req_rdy
        // reads zero together with every other output.
        elig = (s1_adv && !flush && reset) ? (req_vld & ~held) : '0;

        // Rotate the eligible vector so the search starts at the pointer,
        // pick the lowest set bit, then map the offset back to a lane.
        start    = RR_EN ? ptr_q : 2'd0;
        rot      = 3'({elig, elig} >> start);
        gnt_any  = |rot;
        off      = rot[0] ? 2'd0 : (rot[1] ? 2'd1 : 2'd2);
        off_sum  = {1'b0, start} + {1'b0, off};
        gnt_lane = (off_sum >= 3'd3) ? 2'(off_sum - 3'd3) : off_sum[1:0];
        req_rdy  = gnt_any ? (3'b001 << gnt_lane) : '0;
    end

    // ---------------------------------------------------------------
    // Operand mux for the granted lane
    // ---------------------------------------------------------------
    always_comb begin
        g_rs = '0;
        g_rx = '0;
        g_rt = '0;
        g_op = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (gnt_lane == 2'(i)) begin
                g_rs = req_rs[64*i +: 64];
                g_rx = req_rx[64*i +: 64];
                g_rt = req_rt[8*i +: 8];
                g_op = req_op[6*i +: 6];
            end
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_lane_d = s1_lane_q;
        s1_rs_d   = s1_rs_q;
        s1_rx_d   = s1_rx_q;
        s1_rt_d   = s1_rt_q;
        s1_op_d   = s1_op_q;
        s2_v_d    = s2_v_q;
        s2_lane_d = s2_lane_q;
        s2_data_d = s2_data_q;
        ptr_d     = ptr_q;

        if (s2_adv) begin
            s2_v_d    = s1_v_q;
            s2_lane_d = s1_lane_q;
            s2_data_d = sh_rn;
        end

        if (s1_adv) begin
            s1_v_d    = gnt_any;
            s1_lane_d = gnt_any ? gnt_lane : 2'd0;
            s1_rs_d   = gnt_any ? g_rs : 64'd0;
            s1_rx_d   = gnt_any ? g_rx : 64'd0;
            s1_rt_d   = gnt_any ? g_rt : 8'd0;
            s1_op_d   = gnt_any ? g_op : 6'd0;
        end

        if (RR_EN && gnt_any) begin
            ptr_d = (gnt_lane == 2'd2) ? 2'd0 : gnt_lane + 2'd1;
        end

        // Flush drops both stages; an S2 accept in the same cycle has
        // already completed its handshake on the response side.
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: operand and data registers are reset as well, so the
            // shifter and response buses read zero straight out of reset.
            s1_v_q    <= 1'b0;
            s1_lane_q <= 2'd0;
            s1_rs_q   <= 64'd0;
            s1_rx_q   <= 64'd0;
            s1_rt_q   <= 8'd0;
            s1_op_q   <= 6'd0;
            s2_v_q    <= 1'b0;
            s2_lane_q <= 2'd0;
            s2_data_q <= 64'd0;
            ptr_q     <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // the pre-edge value of every other register.
            s1_v_q    <= s1_v_d;
            s1_lane_q <= s1_lane_d;
            s1_rs_q   <= s1_rs_d;
            s1_rx_q   <= s1_rx_d;
            s1_rt_q   <= s1_rt_d;
            s1_op_q   <= s1_op_d;
            s2_v_q    <= s2_v_d;
            s2_lane_q <= s2_lane_d;
            s2_data_q <= s2_data_d;
            ptr_q     <= ptr_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign sh_rs    = s1_v_q ? s1_rs_q   : 64'd0;
    assign sh_rx    = s1_v_q ? s1_rx_q   : 64'd0;
    assign sh_rt    = s1_v_q ? s1_rt_q   : 8'd0;
    assign sh_op    = s1_v_q ? s1_op_q   : 6'd0;
    assign sh_lane  = s1_v_q ? s1_lane_q : 2'd0;
    assign rsp_data = s2_data_q;
    assign busy     = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_shad_share_arb.sv
// ---------------------------------------------------------------------------
// tb_shad_share_arb
//
// Drives directed scenarios and a randomized stream into shad_share_arb,
// supplies the shifter from a behavioural shift function, and checks every
// cycle against a transaction-level model of the arbiter. A second instance
// with fixed priority is observed for its grant order.
// ---------------------------------------------------------------------------
module tb_shad_share_arb;

    logic         clock = 1'b0;
    logic         reset;
    logic [2:0]   req_vld, rsp_rdy;
    logic [191:0] req_rs, req_rx;
    logic [23:0]  req_rt;
    logic [17:0]  req_op;
    logic         flush;

    logic [2:0]   req_rdy, rsp_vld;
    logic [63:0]  sh_rs, sh_rx, sh_rn, rsp_data;
    logic [7:0]   sh_rt;
    logic [5:0]   sh_op;
    logic [1:0]   sh_lane;
    logic         busy;

    logic [2:0]   f_req_rdy, f_rsp_vld;
    logic [63:0]  f_sh_rs, f_sh_rx, f_sh_rn, f_rsp_data;
    logic [7:0]   f_sh_rt;
    logic [5:0]   f_sh_op;
    logic [1:0]   f_sh_lane;
    logic         f_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int glog[$];
    int flog[$];

    always #5 clock = ~clock;

    // Behavioural shifter: op[5] selects a funnel left shift of rs:rx by
    // rt[5:0]; otherwise rt is a signed amount (left if >= 0, else right).
    function automatic logic [63:0] golden(input logic [5:0] op, input logic [63:0] rs,
                                           input logic [63:0] rx, input logic [7:0] rt);
        int n;
        if (op[5]) begin
            n = int'(rt[5:0]);
            return (n == 0) ? rs : ((rs << n) | (rx >> (64 - n)));
        end
        n = int'($signed(rt));
        return (n >= 0) ? (rs << n) : (rs >> (-n));
    endfunction

    assign sh_rn   = golden(sh_op, sh_rs, sh_rx, sh_rt);
    assign f_sh_rn = golden(f_sh_op, f_sh_rs, f_sh_rx, f_sh_rt);

    shad_share_arb #(.NLANE(3), .RR_EN(1'b1)) u_dut (
        .clock(clock), .reset(reset),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_rs(req_rs), .req_rx(req_rx), .req_rt(req_rt), .req_op(req_op),
        .flush(flush),
        .sh_rs(sh_rs), .sh_rx(sh_rx), .sh_rt(sh_rt), .sh_op(sh_op), .sh_lane(sh_lane),
        .sh_rn(sh_rn),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .busy(busy)
    );

    shad_share_arb #(.NLANE(3), .RR_EN(1'b0)) u_fix (
        .clock(clock), .reset(reset),
        .req_vld(req_vld), .req_rdy(f_req_rdy),
        .req_rs(req_rs), .req_rx(req_rx), .req_rt(req_rt), .req_op(req_op),
        .flush(flush),
        .sh_rs(f_sh_rs), .sh_rx(f_sh_rx), .sh_rt(f_sh_rt), .sh_op(f_sh_op), .sh_lane(f_sh_lane),
        .sh_rn(f_sh_rn),
        .rsp_vld(f_rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(f_rsp_data), .busy(f_busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: in-flight ops held as (lane, operands, result);
    // checked on every falling edge, advanced for the coming rising edge.
    // ---------------------------------------------------------------
    bit          m1_v, m2_v;
    int          m1_lane, m2_lane, m_ptr;
    logic [63:0] m1_rs, m1_rx, m1_res, m2_data;
    logic [7:0]  m1_rt;
    logic [5:0]  m1_op;

    initial begin : model
        bit       s2_go, s1_free;
        int       gl, l;
        logic [2:0] want_rdy, want_vld;
        m1_v = 0; m2_v = 0; m_ptr = 0; m1_lane = 0; m2_lane = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("rst_req_rdy", 64'(req_rdy), 64'd0);
                check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
                check("rst_rsp_data", rsp_data, 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_sh_rs", sh_rs, 64'd0);
                m1_v = 0; m2_v = 0; m_ptr = 0;
            end else begin
                s2_go   = m2_v && rsp_rdy[m2_lane];
                s1_free = !m1_v || !m2_v || s2_go;
                gl = -1;
                if (s1_free && !flush) begin
                    for (int k = 0; k < 3; k++) begin
                        l = (m_ptr + k) % 3;
                        if (gl < 0 && req_vld[l] && !(m1_v && m1_lane == l) && !(m2_v && m2_lane == l))
                            gl = l;
                    end
                end
                want_rdy = (gl >= 0) ? 3'(1 << gl) : 3'b000;
                want_vld = m2_v ? 3'(1 << m2_lane) : 3'b000;

                check("req_rdy", 64'(req_rdy), 64'(want_rdy));
                check("rsp_vld", 64'(rsp_vld), 64'(want_vld));
                check("busy", 64'(busy), 64'(m1_v || m2_v));
                check("sh_lane", 64'(sh_lane), m1_v ? 64'(m1_lane) : 64'd0);
                check("sh_rs", sh_rs, m1_v ? m1_rs : 64'd0);
                check("sh_rx", sh_rx, m1_v ? m1_rx : 64'd0);
                check("sh_rt", 64'(sh_rt), m1_v ? 64'(m1_rt) : 64'd0);
                check("sh_op", 64'(sh_op), m1_v ? 64'(m1_op) : 64'd0);
                if (m2_v) check("rsp_data", rsp_data, m2_data);

                for (int i = 0; i < 3; i++) begin
                    if (req_vld[i] && req_rdy[i]) glog.push_back(i);
                    if (req_vld[i] && f_req_rdy[i]) flog.push_back(i);
                end

                if (flush) begin
                    m1_v = 0;
                    m2_v = 0;
                end else begin
                    if (!m2_v || s2_go) begin
                        m2_v = m1_v; m2_lane = m1_lane; m2_data = m1_res;
                    end
                    if (s1_free) begin
                        m1_v = (gl >= 0);
                        if (gl >= 0) begin
                            m1_lane = gl;
                            m1_rs   = req_rs[64*gl +: 64];
                            m1_rx   = req_rx[64*gl +: 64];
                            m1_rt   = req_rt[8*gl +: 8];
                            m1_op   = req_op[6*gl +: 6];
                            m1_res  = golden(m1_op, m1_rs, m1_rx, m1_rt);
                        end
                    end
                end
                if (gl >= 0) m_ptr = (gl + 1) % 3;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req_vld = 3'b000;
        rsp_rdy = 3'b111;
        flush   = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [5:0] op, input logic [63:0] rs,
                            input logic [63:0] rx, input logic [7:0] rt);
        req_op[6*l +: 6]  = op;
        req_rs[64*l +: 64] = rs;
        req_rx[64*l +: 64] = rx;
        req_rt[8*l +: 8]   = rt;
    endtask

    task automatic rand_lanes();
        for (int l = 0; l < 3; l++)
            set_lane(l, 6'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic rand_run(input int cycles);
        repeat (cycles) begin
            req_vld = 3'($urandom);
            rsp_rdy = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            flush   = ($urandom_range(0, 31) == 0);
            rand_lanes();
            tick();
        end
    endtask

    // ---------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------
    initial begin
        reset  = 1'b0;
        req_rs = '0; req_rx = '0; req_rt = '0; req_op = '0;
        idle();
        repeat (2) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_sh_lane", 64'(sh_lane), 64'd0);
        reset = 1'b1;

        // Single op on lane A: 1 << 4
        set_lane(0, 6'b000010, 64'h1, 64'h0, 8'd4);
        req_vld = 3'b001;
        #1 check("single_grant", 64'(req_rdy), 64'h1);
        tick();
        req_vld = 3'b000;
        check("single_not_early", 64'(rsp_vld), 64'h0);
        tick();
        check("single_rsp_vld", 64'(rsp_vld), 64'h1);
        check("single_rsp_data", rsp_data, 64'h10);
        repeat (3) tick();

        // Round-robin with all lanes requesting
        do_reset();
        glog.delete();
        flog.delete();
        rand_lanes();
        req_vld = 3'b111;
        repeat (6) tick();
        req_vld = 3'b000;
        repeat (3) tick();
        check("rr_count", 64'(glog.size()), 64'd6);
        if (glog.size() >= 6)
            for (int i = 0; i < 6; i++) check("rr_order", 64'(glog[i]), 64'(i % 3));
        if (flog.size() >= 2) begin
            check("fixed_first", 64'(flog[0]), 64'd0);
            check("fixed_second", 64'(flog[1]), 64'd1);
        end else begin
            check("fixed_count", 64'(flog.size()), 64'd2);
        end

        // Backpressure on lane B while A and C request
        glog.delete();
        rand_lanes();
        set_lane(1, 6'b000010, 64'h3, 64'h0, 8'd8);
        rsp_rdy = 3'b101;
        req_vld = 3'b010;
        tick();
        req_vld = 3'b101;
        tick();
        repeat (3) begin
            check("bp_req_rdy", 64'(req_rdy), 64'h0);
            check("bp_rsp_vld", 64'(rsp_vld), 64'h2);
            check("bp_rsp_data", rsp_data, 64'h300);
            tick();
        end
        rsp_rdy = 3'b111;
        #1 check("bp_release_grant", 64'(req_rdy), 64'h1);
        tick();
        req_vld = 3'b000;
        repeat (4) tick();
        check("bp_count", 64'(glog.size()), 64'd3);
        if (glog.size() >= 3) begin
            check("bp_order0", 64'(glog[0]), 64'd1);
            check("bp_order1", 64'(glog[1]), 64'd2);
            check("bp_order2", 64'(glog[2]), 64'd0);
        end

        // Funnel op on lane B
        set_lane(1, 6'b100100, 64'h0, 64'hFFFF_0000_0000_0000, 8'd8);
        req_vld = 3'b010;
        #1 check("funnel_grant", 64'(req_rdy), 64'h2);
        tick();
        req_vld = 3'b000;
        check("funnel_sh_lane", 64'(sh_lane), 64'd1);
        check("funnel_sh_rx", sh_rx, 64'hFFFF_0000_0000_0000);
        tick();
        check("funnel_rsp_vld", 64'(rsp_vld), 64'h2);
        check("funnel_rsp_data", rsp_data, 64'hFF);
        repeat (3) tick();

        // Flush with both stages full; pointer must survive (next is C)
        rsp_rdy = 3'b110;
        req_vld = 3'b001;
        tick();
        req_vld = 3'b010;
        tick();
        req_vld = 3'b000;
        check("flush_pre_busy", 64'(busy), 64'd1);
        check("flush_pre_rsp_vld", 64'(rsp_vld), 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_rsp_vld", 64'(rsp_vld), 64'h0);
        check("flush_busy", 64'(busy), 64'd0);
        rsp_rdy = 3'b111;
        req_vld = 3'b111;
        #1 check("flush_ptr_kept", 64'(req_rdy), 64'h4);
        tick();
        req_vld = 3'b000;
        repeat (3) tick();

        // Randomized traffic with an asynchronous reset pulse mid-stream
        rand_run(1500);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("arst_req_rdy", 64'(req_rdy), 64'd0);
        check("arst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("arst_rsp_data", rsp_data, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_sh_rs", sh_rs, 64'd0);
        check("arst_sh_lane", 64'(sh_lane), 64'd0);
        req_vld = 3'b111;
        rsp_rdy = 3'b111;
        flush   = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        #1 check("post_reset_first_grant", 64'(req_rdy), 64'h1);
        rand_run(1500);
        idle();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
